// File: rtl/meter_pkg.sv
// Shared definitions for the slow-clock period/high-time meter.
package meter_pkg;

    localparam int unsigned W_DEFAULT = 16;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MEAS = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_MEAS = ST_MEAS
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a delayed copy for rising-edge detection of a slow async input.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // Flops reset high so a level already high at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= sig;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow waveform in system-clock cycles, with a sticky timeout.
module clk_period_meter
    import meter_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_sig,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high,
    output logic         o_valid,
    output logic         o_timeout
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         level;
    logic         rise;
    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] hcnt;

    sync_edge_det u_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (i_sig),
        .level (level),
        .rise  (rise)
    );

    // First rise arms; each later rise publishes the window just closed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        cnt   <= W'(1);
                        hcnt  <= W'(1);
                        state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        o_period  <= cnt;
                        o_high    <= hcnt;
                        o_valid   <= 1'b1;
                        o_timeout <= 1'b0;
                        cnt       <= W'(1);
                        hcnt      <= W'(1);
                    end else if (cnt == CNT_MAX) begin
                        // Counter saturated without an edge: flag and re-arm.
                        o_timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt  <= cnt + W'(1);
                        hcnt <= hcnt + W'(level);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
